dram_write_data_serializer: RTL

- Write-direction counterpart of the DRAM read data buffer.
- Takes one 64-bit write word plus a burst_size_t from the write-data FIFO when the command scheduler issues a WRITE.
- After a fixed write latency, serializes the word onto the x8 DQ bus as byte pairs, one pair per clk cycle: dq_pos on the rising half, dq_neg on the falling half.
- Also generates the DQS preamble, data and postamble pattern and the DM byte masks; the downstream DDR output cell/PHY model turns each pair into double-data-rate pins.

---
 rtl/dram_write_data_serializer_pkg.sv | 11 +
 rtl/dram_write_data_serializer_if.sv | 53 +++++
 rtl/dram_write_data_serializer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dram_write_data_serializer_pkg.sv
// Shared types for the DRAM write data path.
package dram_write_data_serializer_pkg;

  typedef enum logic [1:0] {
    ONE_BYTE    = 2'd0,
    TWO_BYTES   = 2'd1,
    FOUR_BYTES  = 2'd2,
    EIGHT_BYTES = 2'd3
  } burst_size_t;

endpackage

// File: rtl/dram_write_data_serializer_if.sv
// Write-data FIFO handshake plus DQ/DQS/DM pin-pair bus of the write serializer.
// DRAM_WRITE_DBI_EN adds the dbi_pos/dbi_neg data-bus-inversion flags.
interface dram_write_data_serializer_if;
  import dram_write_data_serializer_pkg::*;

  logic        write_issued;
  logic        wdata_valid;
  logic [63:0] wdata;
  burst_size_t wburst_size;
  logic        wdata_pop;
  logic [7:0]  dq_pos;
  logic [7:0]  dq_neg;
  logic        dm_pos;
  logic        dm_neg;
  logic        dq_oe;
  logic        dqs_pos;
  logic        dqs_neg;
  logic        dqs_oe;
  logic        busy;
  logic        write_done;
  logic        wr_error;
`ifdef DRAM_WRITE_DBI_EN
  logic        dbi_pos;
  logic        dbi_neg;

  modport master (
    output write_issued, wdata_valid, wdata, wburst_size,
    input  wdata_pop, dq_pos, dq_neg, dm_pos, dm_neg, dq_oe,
           dqs_pos, dqs_neg, dqs_oe, busy, write_done, wr_error,
           dbi_pos, dbi_neg
  );

  modport slave (
    input  write_issued, wdata_valid, wdata, wburst_size,
    output wdata_pop, dq_pos, dq_neg, dm_pos, dm_neg, dq_oe,
           dqs_pos, dqs_neg, dqs_oe, busy, write_done, wr_error,
           dbi_pos, dbi_neg
  );
`else
  modport master (
    output write_issued, wdata_valid, wdata, wburst_size,
    input  wdata_pop, dq_pos, dq_neg, dm_pos, dm_neg, dq_oe,
           dqs_pos, dqs_neg, dqs_oe, busy, write_done, wr_error
  );

  modport slave (
    input  write_issued, wdata_valid, wdata, wburst_size,
    output wdata_pop, dq_pos, dq_neg, dm_pos, dm_neg, dq_oe,
           dqs_pos, dqs_neg, dqs_oe, busy, write_done, wr_error
  );
`endif

endinterface

// File: rtl/dram_write_data_serializer.sv
// Serializes one 64-bit write word into DDR byte pairs with DQS preamble/postamble and DM masks.
// Optional DRAM_WRITE_DBI_EN inverts bytes with more than four zero bits and flags them on dbi_pos/dbi_neg.
module dram_write_data_serializer
  import dram_write_data_serializer_pkg::*;
#(
  parameter int unsigned WRITE_LATENCY = 2
) (
  input logic                          clk,
  input logic                          rst,
  dram_write_data_serializer_if.slave  bus
);

  typedef enum logic [2:0] {
    WIDLE,
    WWAIT,
    WPRE,
    WBURST,
    WPOST
  } wstate_t;

  localparam logic [3:0] WAIT_INIT = (WRITE_LATENCY > 1) ? 4'(WRITE_LATENCY - 2) : 4'd0;

  wstate_t     state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]  beat_idx_q, beat_idx_d;
  logic [63:0] word_q, word_d;
  burst_size_t size_q, size_d;

  logic        accept;
  logic        err_set;

  logic [7:0]  dq_pos_q, dq_pos_d;
  logic [7:0]  dq_neg_q, dq_neg_d;
  logic        dm_pos_q, dm_pos_d;
  logic        dm_neg_q, dm_neg_d;
  logic        dq_oe_q, dq_oe_d;
  logic        dqs_pos_q, dqs_pos_d;
  logic        dqs_neg_q, dqs_neg_d;
  logic        dqs_oe_q, dqs_oe_d;
  logic        busy_q, busy_d;
  logic        write_done_q, write_done_d;
  logic        wr_error_q, wr_error_d;
`ifdef DRAM_WRITE_DBI_EN
  logic        dbi_pos_q, dbi_pos_d;
  logic        dbi_neg_q, dbi_neg_d;
`endif

  assign accept  = !rst && bus.write_issued && (state_q == WIDLE) && bus.wdata_valid;
  assign err_set = bus.write_issued && ((state_q != WIDLE) || !bus.wdata_valid);

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    beat_cnt_d = beat_cnt_q;
    beat_idx_d = beat_idx_q;
    word_d     = word_q;
    size_d     = size_q;
    case (state_q)
      WIDLE: begin
        if (accept) begin
          word_d = bus.wdata;
          size_d = bus.wburst_size;
          if (WRITE_LATENCY > 1) begin
            state_d = WWAIT;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = WPRE;
          end
        end
      end
      WWAIT: begin
        if (wait_q == 4'd0) state_d = WPRE;
        else                wait_d  = wait_q - 4'd1;
      end
      WPRE: begin
        state_d    = WBURST;
        beat_idx_d = 2'd0;
        case (size_q)
          ONE_BYTE, TWO_BYTES: beat_cnt_d = 2'd0;
          FOUR_BYTES:          beat_cnt_d = 2'd1;
          default:             beat_cnt_d = 2'd3;
        endcase
      end
      WBURST: begin
        if (beat_cnt_q == 2'd0) begin
          state_d = WPOST;
        end else begin
          beat_cnt_d = beat_cnt_q - 2'd1;
          beat_idx_d = beat_idx_q + 2'd1;
        end
      end
      WPOST:   state_d = WIDLE;
      default: state_d = WIDLE;
    endcase
  end

  // Pin values are decoded from the next state so they land in registers aligned with that state.
  always_comb begin
    dq_pos_d     = 8'd0;
    dq_neg_d     = 8'd0;
    dm_pos_d     = 1'b0;
    dm_neg_d     = 1'b0;
    dq_oe_d      = 1'b0;
    dqs_pos_d    = 1'b0;
    dqs_neg_d    = 1'b0;
    dqs_oe_d     = 1'b0;
    write_done_d = 1'b0;
    busy_d       = (state_d != WIDLE);
    wr_error_d   = wr_error_q | err_set;
`ifdef DRAM_WRITE_DBI_EN
    dbi_pos_d    = 1'b0;
    dbi_neg_d    = 1'b0;
`endif
    case (state_d)
      WPRE: dqs_oe_d = 1'b1;
      WBURST: begin
        dq_oe_d   = 1'b1;
        dqs_oe_d  = 1'b1;
        dqs_pos_d = 1'b1;
        dq_pos_d  = word_d[{beat_idx_d, 4'd0} +: 8];
        dm_neg_d  = (size_d == ONE_BYTE) && (beat_idx_d == 2'd0);
        dq_neg_d  = dm_neg_d ? 8'd0 : word_d[{beat_idx_d, 4'd8} +: 8];
`ifdef DRAM_WRITE_DBI_EN
        if ($countones(dq_pos_d) < 4) begin
          dq_pos_d  = ~dq_pos_d;
          dbi_pos_d = 1'b1;
        end
        if (!dm_neg_d && ($countones(dq_neg_d) < 4)) begin
          dq_neg_d  = ~dq_neg_d;
          dbi_neg_d = 1'b1;
        end
`endif
      end
      WPOST: begin
        dqs_oe_d     = 1'b1;
        write_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WIDLE;
      wait_q       <= 4'd0;
      beat_cnt_q   <= 2'd0;
      beat_idx_q   <= 2'd0;
      word_q       <= 64'd0;
      size_q       <= ONE_BYTE;
      dq_pos_q     <= 8'd0;
      dq_neg_q     <= 8'd0;
      dm_pos_q     <= 1'b0;
      dm_neg_q     <= 1'b0;
      dq_oe_q      <= 1'b0;
      dqs_pos_q    <= 1'b0;
      dqs_neg_q    <= 1'b0;
      dqs_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      write_done_q <= 1'b0;
      wr_error_q   <= 1'b0;
`ifdef DRAM_WRITE_DBI_EN
      dbi_pos_q    <= 1'b0;
      dbi_neg_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      beat_cnt_q   <= beat_cnt_d;
      beat_idx_q   <= beat_idx_d;
      word_q       <= word_d;
      size_q       <= size_d;
      dq_pos_q     <= dq_pos_d;
      dq_neg_q     <= dq_neg_d;
      dm_pos_q     <= dm_pos_d;
      dm_neg_q     <= dm_neg_d;
      dq_oe_q      <= dq_oe_d;
      dqs_pos_q    <= dqs_pos_d;
      dqs_neg_q    <= dqs_neg_d;
      dqs_oe_q     <= dqs_oe_d;
      busy_q       <= busy_d;
      write_done_q <= write_done_d;
      wr_error_q   <= wr_error_d;
`ifdef DRAM_WRITE_DBI_EN
      dbi_pos_q    <= dbi_pos_d;
      dbi_neg_q    <= dbi_neg_d;
`endif
    end
  end

  assign bus.wdata_pop  = accept;
  assign bus.dq_pos     = dq_pos_q;
  assign bus.dq_neg     = dq_neg_q;
  assign bus.dm_pos     = dm_pos_q;
  assign bus.dm_neg     = dm_neg_q;
  assign bus.dq_oe      = dq_oe_q;
  assign bus.dqs_pos    = dqs_pos_q;
  assign bus.dqs_neg    = dqs_neg_q;
  assign bus.dqs_oe     = dqs_oe_q;
  assign bus.busy       = busy_q;
  assign bus.write_done = write_done_q;
  assign bus.wr_error   = wr_error_q;
`ifdef DRAM_WRITE_DBI_EN
  assign bus.dbi_pos    = dbi_pos_q;
  assign bus.dbi_neg    = dbi_neg_q;
`endif

endmodule
